hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Parametrised hazard unit for the 5-stage core (F/D/E/M/W). Sits beside the pipeline registers and drives all stall/flush controls.
// - Replaces pure E/M tag compares with stateful tracking:
//   - per-GPR busy scoreboard for long-latency writers (load, unaligned load, mfc0);
//   - in-flight counters for HI/LO and CP0 writers;
//   - drain FSM that holds the flush until an outstanding I-fetch returns.
// - Also keeps a saturating hazard-cycle counter for performance monitoring.
// PARAMETERS
// NUM_REGS  32  architectural GPRs; register 0 is never busy
// REG_AW    5   register index width, $clog2(NUM_REGS)
// HILO_MAX  3   max in-flight HI/LO writers (E..W)
// CP0_MAX   3   max in-flight CP0/TLB writers (E..W)
// CNT_W     32  width of perf counter hz_cycles
// PORTS
// clk           in   1         clock
// reset         in   1         synchronous, active-high
// i_data_ok     in   1         I-side response ready (0 = fetch waiting)
// d_data_ok     in   1         D-side response ready
// mult_ok       in   1         multiplier/divider result ready
// is_wait       in   1         WAIT instruction holding the pipe
// exc_valid     in   1         exception or ERET taken in M
// dec_valid     in   1         valid instruction in D
// dec_srca      in   REG_AW    D source A
// dec_srcb      in   REG_AW    D source B
// dec_use_a     in   1         D reads srca
// dec_use_b     in   1         D reads srcb
// dec_branch    in   1         D is branch/jump-register (resolves in D)
// dec_cmp_b     in   1         branch also compares srcb (BEQ/BNE)
// dec_long_wr   in   1         D is a long-latency GPR writer
// dec_wr_reg    in   REG_AW    D destination
// dec_hilo_rd   in   1         D reads HI or LO
// dec_hilo_wr   in   1         D writes HI or LO
// dec_cp0_wr    in   1         D writes CP0 or is TLBR/TLBP
// ex_regwrite   in   1         E writes a GPR (value not yet forwardable to D)
// ex_wr_reg     in   REG_AW    E destination
// wb_valid      in   1         W retires this cycle
// wb_reg        in   REG_AW    W destination
// wb_long       in   1         W is a long-latency writer
// wb_hilo       in   1         W writes HI/LO
// wb_cp0        in   1         W writes CP0/TLB
// stall_f       out  1         hold PC
// stall_d       out  1         hold D register
// stall_e       out  1         hold E register
// stall_m       out  1         hold M register
// flush_d       out  1         bubble into D
// flush_e       out  1         bubble into E
// flush_m       out  1         bubble into M
// flush_w       out  1         bubble into W
// busy_vec      out  NUM_REGS  scoreboard state, bit r = GPR r pending
// hz_cycles     out  CNT_W     count of cycles with hz=1
// BEHAVIOUR
// - Reset (sync): busy_vec=0, hilo_cnt=0, cp0_cnt=0, state=RUN, hz_cycles=0.
//   While reset=1: flush_d/e/m/w=1 and all stalls=0.
// - mem = ~i_data_ok | ~d_data_ok.
// - Hazard terms:
//   - raw = (dec_use_a & busy[srca]) | (dec_use_b & busy[srcb]).
//   - br = dec_branch & ex_regwrite & ex_wr_reg!=0 & (ex_wr_reg==srca | dec_cmp_b & ex_wr_reg==srcb).
//   - hl = dec_hilo_rd & hilo_cnt!=0 | dec_hilo_wr & hilo_cnt==HILO_MAX.
//   - c0 = cp0_cnt!=0 (serialise everything behind a CP0 writer).
//   - hz = dec_valid & (raw|br|hl|c0).
// - Control outputs:
//   - stall_f = stall_d = mem | hz | is_wait.
//   - stall_e = ~d_data_ok | ~mult_ok | is_wait.
//   - stall_m = ~d_data_ok | is_wait.
//   - flush_d = exc_valid | state==DRAIN.
//   - flush_e = (hz | ~i_data_ok) & ~stall_e | exc_valid.
//   - flush_m = ~mult_ok & ~stall_m.
//   - flush_w = ~d_data_ok | is_wait | exc_valid.
// - Issue: fire = dec_valid & ~stall_d & ~exc_valid.
// - Scoreboard, per register r != 0, next-state order:
//   - set if fire & dec_long_wr & dec_wr_reg==r;
//   - else clear if wb_valid & wb_long & wb_reg==r;
//   - else hold.
//   - Set and clear on the same r in one cycle: set wins.
//   - busy[0] is always 0.
// - Counters (hilo_cnt, cp0_cnt): +1 on fire & writer flag, -1 on wb_valid & wb flag.
//   - Simultaneous inc and dec: count unchanged.
//   - Never exceeds MAX: the hl stall guarantees it. c0 stalls any fire while cp0_cnt!=0.
//   - Underflow is a bug; assertion required.
// - exc_valid: clear all busy bits and both counters to 0 next cycle. Only the W instruction is older, and it retires this cycle.
// - FSM RUN/DRAIN:
//   - RUN -> DRAIN on exc_valid & ~i_data_ok.
//   - DRAIN -> RUN on i_data_ok (flush_d held through that cycle).
//   - exc_valid while in DRAIN: stay in DRAIN.
// - hz_cycles: +1 each cycle hz=1; saturates at all-ones (no wrap).
// - All state updates are gated by nothing except reset. Stalls do not freeze the scoreboard; only fire and wb change it.
// TESTING
// - Load r5, then dependent ADD r5 in D: stall_d=1 until wb_valid&wb_long&wb_reg=5; busy_vec[5] 1->0 that cycle; ADD fires next cycle.
// - Same-cycle wb of r7 load and fire of new r7 load: busy_vec[7] stays 1.
// - Three MULTs back-to-back, then a 4th: hilo_cnt=3, 4th stalls. MFLO stalls while hilo_cnt!=0 and fires the cycle after the count reaches 0.
// - exc_valid with busy_vec=0x24 and i_data_ok=0 for 3 cycles: busy_vec=0 next cycle; flush_d=1 for 4 cycles; state returns to RUN.
// - BEQ r3,r4 in D with E writing r4: stall_d=1, flush_e=1 for 1 cycle. BLTZ r3 with E writing r4: no stall.
// - 2^CNT_W hazard cycles with CNT_W=4: hz_cycles holds at 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: GPR busy scoreboard, HI/LO and CP0 in-flight
// counters, I-fetch drain FSM and a saturating hazard-cycle counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int HILO_MAX = 3,
  parameter int CP0_MAX  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_data_ok,
  input  logic                d_data_ok,
  input  logic                mult_ok,
  input  logic                is_wait,
  input  logic                exc_valid,
  input  logic                dec_valid,
  input  logic [REG_AW-1:0]   dec_srca,
  input  logic [REG_AW-1:0]   dec_srcb,
  input  logic                dec_use_a,
  input  logic                dec_use_b,
  input  logic                dec_branch,
  input  logic                dec_cmp_b,
  input  logic                dec_long_wr,
  input  logic [REG_AW-1:0]   dec_wr_reg,
  input  logic                dec_hilo_rd,
  input  logic                dec_hilo_wr,
  input  logic                dec_cp0_wr,
  input  logic                ex_regwrite,
  input  logic [REG_AW-1:0]   ex_wr_reg,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_reg,
  input  logic                wb_long,
  input  logic                wb_hilo,
  input  logic                wb_cp0,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                stall_m,
  output logic                flush_d,
  output logic                flush_e,
  output logic                flush_m,
  output logic                flush_w,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    hz_cycles
);

  // state | meaning
  // RUN   | normal operation
  // DRAIN | exception taken while an I-fetch is outstanding; hold flush_d until it returns
  localparam logic RUN   = 1'b0;
  localparam logic DRAIN = 1'b1;

  localparam int HW = $clog2(HILO_MAX + 1);
  localparam int CW = $clog2(CP0_MAX + 1);

  logic                state;
  logic [NUM_REGS-1:0] busyVec;
  logic [NUM_REGS-1:0] busyNext;
  logic [HW-1:0]       hiloCnt;
  logic [CW-1:0]       cp0Cnt;
  logic [CNT_W-1:0]    hzCycles;

  logic mem, raw, br, hl, c0, hz, fire;
  logic hiloInc, hiloDec, cp0Inc, cp0Dec;
  logic stallCore, stallE, stallM;

  assign mem = ~i_data_ok | ~d_data_ok;
  assign raw = (dec_use_a & busyVec[dec_srca]) | (dec_use_b & busyVec[dec_srcb]);
  assign br  = dec_branch & ex_regwrite & (ex_wr_reg != '0) &
               ((ex_wr_reg == dec_srca) | (dec_cmp_b & (ex_wr_reg == dec_srcb)));
  assign hl  = (dec_hilo_rd & (hiloCnt != '0)) | (dec_hilo_wr & (hiloCnt == HW'(HILO_MAX)));
  assign c0  = cp0Cnt != '0;
  assign hz  = dec_valid & (raw | br | hl | c0);

  assign stallCore = mem | hz | is_wait;
  assign stallE    = ~d_data_ok | ~mult_ok | is_wait;
  assign stallM    = ~d_data_ok | is_wait;
  assign fire      = dec_valid & ~stallCore & ~exc_valid;

  // Reset forces a full-pipe flush with no stalls so the bubbles actually advance.
  assign stall_f = ~reset & stallCore;
  assign stall_d = ~reset & stallCore;
  assign stall_e = ~reset & stallE;
  assign stall_m = ~reset & stallM;
  assign flush_d = reset | exc_valid | (state == DRAIN);
  assign flush_e = reset | ((hz | ~i_data_ok) & ~stallE) | exc_valid;
  assign flush_m = reset | (~mult_ok & ~stallM);
  assign flush_w = reset | ~d_data_ok | is_wait | exc_valid;

  assign hiloInc = fire & dec_hilo_wr;
  assign hiloDec = wb_valid & wb_hilo;
  assign cp0Inc  = fire & dec_cp0_wr;
  assign cp0Dec  = wb_valid & wb_cp0;

  // Set beats clear so a new writer re-arms a register its predecessor is retiring.
  always_comb begin
    busyNext = busyVec;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (fire && dec_long_wr && dec_wr_reg == REG_AW'(r))
        busyNext[r] = 1'b1;
      else if (wb_valid && wb_long && wb_reg == REG_AW'(r))
        busyNext[r] = 1'b0;
    end
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busyVec  <= '0;
      hiloCnt  <= '0;
      cp0Cnt   <= '0;
      state    <= RUN;
      hzCycles <= '0;
    end else begin
      if (exc_valid) begin
        busyVec <= '0;
        hiloCnt <= '0;
        cp0Cnt  <= '0;
      end else begin
        busyVec <= busyNext;
        if (hiloInc && !hiloDec) hiloCnt <= hiloCnt + HW'(1);
        else if (!hiloInc && hiloDec) hiloCnt <= hiloCnt - HW'(1);
        if (cp0Inc && !cp0Dec) cp0Cnt <= cp0Cnt + CW'(1);
        else if (!cp0Inc && cp0Dec) cp0Cnt <= cp0Cnt - CW'(1);
      end

      case (state)
        RUN:     if (exc_valid && !i_data_ok) state <= DRAIN;
        DRAIN:   if (!exc_valid && i_data_ok) state <= RUN;
        default: state <= RUN;
      endcase

      if (hz && hzCycles != '1) hzCycles <= hzCycles + CNT_W'(1);
    end
  end

  // A retirement with nothing in flight means the pipeline lost track of a writer.
  always_ff @(posedge clk) begin
    if (!reset && !exc_valid) begin
      assert (!(hiloDec && !hiloInc && hiloCnt == '0));
      assert (!(cp0Dec && !cp0Inc && cp0Cnt == '0));
    end
  end

  assign busy_vec  = busyVec;
  assign hz_cycles = hzCycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a combinational control table plus
// hand-written multi-cycle sequences (load-use, MULT/MFLO, CP0, exception drain, perf counter).
module tb_hazard_scoreboard;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic i_data_ok, d_data_ok, mult_ok, is_wait, exc_valid, dec_valid;
  logic [4:0] dec_srca, dec_srcb, dec_wr_reg, ex_wr_reg, wb_reg;
  logic dec_use_a, dec_use_b, dec_branch, dec_cmp_b, dec_long_wr;
  logic dec_hilo_rd, dec_hilo_wr, dec_cp0_wr, ex_regwrite;
  logic wb_valid, wb_long, wb_hilo, wb_cp0;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic [31:0] busy_vec;
  logic [CNT_W-1:0] hz_cycles;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .HILO_MAX(3), .CP0_MAX(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_data_ok(i_data_ok), .d_data_ok(d_data_ok), .mult_ok(mult_ok), .is_wait(is_wait),
    .exc_valid(exc_valid), .dec_valid(dec_valid), .dec_srca(dec_srca), .dec_srcb(dec_srcb),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_branch(dec_branch), .dec_cmp_b(dec_cmp_b),
    .dec_long_wr(dec_long_wr), .dec_wr_reg(dec_wr_reg), .dec_hilo_rd(dec_hilo_rd),
    .dec_hilo_wr(dec_hilo_wr), .dec_cp0_wr(dec_cp0_wr), .ex_regwrite(ex_regwrite),
    .ex_wr_reg(ex_wr_reg), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_long(wb_long),
    .wb_hilo(wb_hilo), .wb_cp0(wb_cp0),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .busy_vec(busy_vec), .hz_cycles(hz_cycles)
  );

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
  typedef struct {
    logic       iok, dok, mok, wt, exc, dv;
    logic [4:0] srca, srcb;
    logic       ua, ub, brn, cmpb, exw;
    logic [4:0] exr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [7:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    i_data_ok = 1; d_data_ok = 1; mult_ok = 1; is_wait = 0; exc_valid = 0;
    dec_valid = 0; dec_srca = 0; dec_srcb = 0; dec_use_a = 0; dec_use_b = 0;
    dec_branch = 0; dec_cmp_b = 0; dec_long_wr = 0; dec_wr_reg = 0;
    dec_hilo_rd = 0; dec_hilo_wr = 0; dec_cp0_wr = 0; ex_regwrite = 0; ex_wr_reg = 0;
    wb_valid = 0; wb_reg = 0; wb_long = 0; wb_hilo = 0; wb_cp0 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] r);
    idle(); dec_valid = 1; dec_long_wr = 1; dec_wr_reg = r;
  endtask

  initial begin
    //          iok dok mok wt exc dv srca srcb ua ub brn cmpb exw exr  expected
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0100};
    vecs[2]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0001};
    vecs[3]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0010_0010};
    vecs[4]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0001};
    vecs[5]  = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_1101};
    vecs[6]  = '{1, 1, 1, 0, 0, 1, 3, 4, 1, 1, 1, 1, 1, 4, 8'b1100_0100}; // BEQ r3,r4 vs E r4
    vecs[7]  = '{1, 1, 1, 0, 0, 1, 3, 0, 1, 0, 1, 0, 1, 4, 8'b0000_0000}; // BLTZ r3 vs E r4
    vecs[8]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 8'b0000_0000}; // E writes r0
    vecs[9]  = '{1, 1, 1, 0, 0, 1, 3, 4, 1, 1, 1, 1, 1, 3, 8'b1100_0100};
    vecs[10] = '{1, 1, 1, 0, 0, 0, 3, 0, 1, 0, 1, 0, 1, 3, 8'b0000_0000}; // D not valid
    vecs[11] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0001};
    vecs[12] = '{1, 1, 0, 0, 1, 1, 3, 0, 1, 0, 1, 0, 1, 3, 8'b1110_1111};

    idle();
    i_data_ok = 0;
    reset = 1;
    tick(); tick();
    chk("reset_ctl", 64'(ctl()), 64'h0F);
    idle();
    #1 reset = 0;
    tick();
    chk("reset_busy", 64'(busy_vec), 0);
    chk("reset_hz", 64'(hz_cycles), 0);

    for (int i = 0; i < 13; i++) begin
      idle();
      i_data_ok = vecs[i].iok; d_data_ok = vecs[i].dok; mult_ok = vecs[i].mok;
      is_wait = vecs[i].wt; exc_valid = vecs[i].exc; dec_valid = vecs[i].dv;
      dec_srca = vecs[i].srca; dec_srcb = vecs[i].srcb; dec_use_a = vecs[i].ua;
      dec_use_b = vecs[i].ub; dec_branch = vecs[i].brn; dec_cmp_b = vecs[i].cmpb;
      ex_regwrite = vecs[i].exw; ex_wr_reg = vecs[i].exr;
      #1;
      chk($sformatf("vec%0d", i), 64'(ctl()), 64'(vecs[i].exp));
      tick();
    end
    idle(); #1;
    chk("table_busy_idle", 64'(busy_vec), 0);

    // load r5, then dependent ADD waits for its writeback
    load(5); #1;
    chk("ld5_fire", 64'(stall_d), 0);
    tick();
    idle(); dec_valid = 1; dec_use_a = 1; dec_srca = 5; #1;
    chk("add_stall1", 64'(stall_d), 1);
    tick();
    chk("busy5", 64'(busy_vec), 32'h20);
    wb_valid = 1; wb_long = 1; wb_reg = 5; #1;
    chk("add_stall_wb", 64'(stall_d), 1);
    tick();
    chk("busy5_clr", 64'(busy_vec), 0);
    wb_valid = 0; wb_long = 0; #1;
    chk("add_fire", 64'(stall_d), 0);
    tick();

    // r7 retire and re-issue in the same cycle: set wins
    load(7); tick();
    load(7); wb_valid = 1; wb_long = 1; wb_reg = 7; #1;
    chk("ld7_refire", 64'(stall_d), 0);
    tick();
    chk("busy7_kept", 64'(busy_vec), 32'h80);
    idle(); wb_valid = 1; wb_long = 1; wb_reg = 7; tick();
    chk("busy7_clr", 64'(busy_vec), 0);

    // MULT x3 fills HI/LO tracking; 4th stalls; MFLO waits for drain
    for (int k = 0; k < 4; k++) begin
      idle(); dec_valid = 1; dec_hilo_wr = 1; #1;
      chk($sformatf("mult%0d_stall", k), 64'(stall_d), (k == 3) ? 1 : 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle(); dec_valid = 1; dec_hilo_rd = 1;
      if (k < 3) begin wb_valid = 1; wb_hilo = 1; end
      #1;
      chk($sformatf("mflo%0d_stall", k), 64'(stall_d), (k < 3) ? 1 : 0);
      tick();
    end

    // CP0 writer serialises the next instruction until it retires
    idle(); dec_valid = 1; dec_cp0_wr = 1; tick();
    idle(); dec_valid = 1; #1;
    chk("cp0_serial", 64'(stall_d), 1);
    wb_valid = 1; wb_cp0 = 1; tick();
    wb_valid = 0; wb_cp0 = 0; #1;
    chk("cp0_release", 64'(stall_d), 0);
    tick();

    // exception with busy r2,r5 and an outstanding fetch for 3 cycles
    load(2); tick();
    load(5); tick();
    chk("busy_24", 64'(busy_vec), 32'h24);
    idle(); exc_valid = 1; i_data_ok = 0; #1;
    chk("exc_flush_d0", 64'(flush_d), 1);
    tick();
    chk("exc_busy_clr", 64'(busy_vec), 0);
    idle(); i_data_ok = 0; #1;
    chk("drain_flush_d1", 64'(flush_d), 1);
    tick(); #1;
    chk("drain_flush_d2", 64'(flush_d), 1);
    tick();
    i_data_ok = 1; #1;
    chk("drain_flush_d3", 64'(flush_d), 1);
    tick();
    chk("run_flush_d", 64'(flush_d), 0);

    // perf counter saturation with a 4-bit counter
    reset = 1; tick(); #1 reset = 0;
    idle(); dec_valid = 1; dec_branch = 1; dec_use_a = 1; dec_srca = 3;
    ex_regwrite = 1; ex_wr_reg = 3;
    for (int k = 0; k < 10; k++) tick();
    chk("hz_count10", 64'(hz_cycles), 10);
    for (int k = 0; k < 10; k++) tick();
    chk("hz_sat", 64'(hz_cycles), 15);
    idle(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
